// File: rtl/btn_debounce_pkg.sv
// Shared defaults and helpers for the multi-channel button debouncer.
// The default parameter values live here so that the top level and the
// per-channel block agree on them.
package btn_debounce_pkg;

   localparam int DEF_N_CH            = 4;
   localparam int DEF_SYNC_STAGES     = 3;
   localparam int DEF_DEBOUNCE_CYCLES = 100000;
   localparam int DEF_LONG_CYCLES     = 50000000;

   // Number of bits needed to hold every value from 0 up to max_val.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: synchroniser chain, stability counter,
// registered press/release pulses and an optional long-press detector.
// The long-press detector is present only when BTN_DEBOUNCE_LONGPRESS_EN is
// defined; otherwise long_press is tied low and no counter exists.
module btn_debounce_ch
   import btn_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic btn_out,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press
);

   localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sample_s;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   out_q;
   logic                   out_d;
   logic                   press_q;
   logic                   press_d;
   logic                   release_q;
   logic                   release_d;

   assign sample_s = sync_q[SYNC_STAGES-1];

   // Shift the raw level one stage deeper into the synchroniser each cycle.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
   end

   // Count how long the sample has disagreed with the accepted level and
   // flip the level (with a one-cycle pulse) when the disagreement has held
   // for DEBOUNCE_CYCLES cycles. Any agreement restarts the count, so short
   // glitches never reach the output; the compare against CNT_LAST keeps the
   // counter from ever wrapping.
   always_comb begin
      cnt_d     = '0;
      out_d     = out_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sample_s == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d     = '0;
         out_d     = ~out_q;
         press_d   = ~out_q;
         release_d = out_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Debounce state registers; reset forgets all progress and the level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         out_q     <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_out       = out_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN

   localparam int                LONG_W    = cnt_width(LONG_CYCLES);
   localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

   logic [LONG_W-1:0] long_cnt_q;
   logic [LONG_W-1:0] long_cnt_d;
   logic              long_q;
   logic              long_d;

   // Count high cycles of the accepted level, fire once on reaching
   // LONG_CYCLES and then hold the count so the pulse cannot repeat.
   always_comb begin
      long_cnt_d = '0;
      long_d     = 1'b0;
      if (!out_q) begin
         long_cnt_d = '0;
      end else if (long_cnt_q == LONG_MAX) begin
         long_cnt_d = long_cnt_q;
      end else begin
         long_cnt_d = long_cnt_q + LONG_W'(1);
         long_d     = (long_cnt_q == LONG_LAST);
      end
   end

   // Long-press counter and pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         long_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         long_cnt_q <= long_cnt_d;
         long_q     <= long_d;
      end
   end

   assign long_press = long_q;

`else

   assign long_press = 1'b0;

`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// N_CH independent button debouncers sharing one clock and reset.
// Optional long-press detection is enabled with BTN_DEBOUNCE_LONGPRESS_EN;
// without it the long_press outputs stay low.
module btn_debounce_multi
   import btn_debounce_pkg::*;
#(
   parameter int N_CH            = DEF_N_CH,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_out,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_press
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .btn_in        (btn_in[i]),
         .btn_out       (btn_out[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .long_press    (long_press[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi (N_CH=4, SYNC_STAGES=3,
// DEBOUNCE_CYCLES=8, LONG_CYCLES=32). Stimulus pushes expected pulse events
// with their cycle; a monitor pops and compares whenever a pulse appears.
module tb_btn_debounce_multi;

   localparam int LAT  = 11;   // SYNC_STAGES + DEBOUNCE_CYCLES
   localparam int LONG = 32;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn_in;
   logic [3:0] btn_out;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic [3:0] long_press;

   typedef struct {
      int         cyc;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] lng;
      logic [3:0] out;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   int   t_mark;

   btn_debounce_multi #(
      .N_CH            (4),
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (8),
      .LONG_CYCLES     (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_in        (btn_in),
      .btn_out       (btn_out),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int dc, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l, input logic [3:0] o);
      exp_t e;
      e.cyc = cyc + dc; e.press = p; e.rel = r; e.lng = l; e.out = o;
      sb.push_back(e);
   endtask

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare every observed pulse against the scoreboard head and
   // flag expected events whose cycle has passed without a pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: expected at cyc %0d press=%b rel=%b long=%b, no pulse observed (now %0d)",
                     sb[0].cyc, sb[0].press, sb[0].rel, sb[0].lng, cyc);
            void'(sb.pop_front());
         end
         if ((press_pulse | release_pulse | long_press) != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: cyc %0d press=%b rel=%b long=%b, expected none",
                        cyc, press_pulse, release_pulse, long_press);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.cyc != cyc || e.press !== press_pulse || e.rel !== release_pulse ||
                   e.lng !== long_press || e.out !== btn_out) begin
                  errors++;
                  $display("FAIL pulse_event: got cyc %0d press=%b rel=%b long=%b out=%b expected cyc %0d press=%b rel=%b long=%b out=%b",
                           cyc, press_pulse, release_pulse, long_press, btn_out,
                           e.cyc, e.press, e.rel, e.lng, e.out);
               end
            end
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      btn_in = 4'b0000;
      step(3);
      check4("reset_btn_out", btn_out, 4'b0000);
      check4("reset_pulses", press_pulse | release_pulse | long_press, 4'b0000);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step(5);

      // Single press on channel 0, held 30 cycles, then released.
      btn_in[0] = 1'b1;
      push_exp(LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      step(30);
      btn_in[0] = 1'b0;
      push_exp(LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      step(20);

      // Short 5-cycle blip on channel 1 is discarded.
      btn_in[1] = 1'b1;
      step(5);
      btn_in[1] = 1'b0;
      step(20);
      check4("blip5_btn_out", btn_out, 4'b0000);

      // Boundary: 7 cycles is discarded, exactly 8 cycles is accepted.
      btn_in[1] = 1'b1;
      step(7);
      btn_in[1] = 1'b0;
      step(20);
      check4("blip7_btn_out", btn_out, 4'b0000);
      btn_in[1] = 1'b1;
      push_exp(LAT, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
      step(8);
      btn_in[1] = 1'b0;
      push_exp(LAT, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
      step(20);

      // Channel 2 bounces every 3 cycles, then settles high, later released.
      for (int k = 0; k < 10; k++) begin
         btn_in[2] = (k % 2 == 0);
         step(3);
      end
      btn_in[2] = 1'b1;
      push_exp(LAT, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
      step(20);
      btn_in[2] = 1'b0;
      push_exp(LAT, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
      step(20);

      // Reset mid-press (ch0 accepted) and mid-count (ch3 at count 6).
      btn_in[0] = 1'b1;
      push_exp(LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      step(15);
      btn_in[3] = 1'b1;
      step(9);
      rst_n = 1'b0;
      step(1);
      check4("midreset_btn_out", btn_out, 4'b0000);
      check4("midreset_pulses", press_pulse | release_pulse | long_press, 4'b0000);
      step(1);
      rst_n = 1'b1;
      push_exp(LAT, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
      step(20);
      btn_in = 4'b0000;
      push_exp(LAT, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
      step(20);

      // All four pressed together; ch1-3 released early, ch0 held 60 cycles.
      btn_in = 4'b1111;
      t_mark = cyc;
      push_exp(LAT, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
      step(20);
      btn_in = 4'b0001;
      push_exp(LAT, 4'b0000, 4'b1110, 4'b0000, 4'b0001);
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
      push_exp(t_mark + LAT + LONG - cyc, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
      step(40);
      btn_in = 4'b0000;
      push_exp(LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      step(25);

      check4("final_btn_out", btn_out, 4'b0000);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending events expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
